csr_regfile: RTL

Machine-mode CSR register file for the 3-stage pipelined core. It holds `mstatus`, `mie`, `mip`, `mtvec`, `mepc`, `mcause`, `mscratch` and `mcycle`/`mcycleh`. It executes CSR read/modify/write instructions, performs the trap-entry and `mret` state updates, and samples the timer and external interrupt lines into `mip`. Its register outputs drive the interrupt-detect / trap-vector logic, which returns `trap_taken` through the core.

---
 rtl/csr_regfile.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: mstatus/mie/mip/mtvec/mepc/mcause/mscratch and the
// 64-bit mcycle counter, with CSR read-modify-write, trap entry, mret and irq sampling.
module csr_regfile #(
    parameter int          DW          = 32,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   csr_addr,
    input  logic [1:0]    csr_op,
    input  logic [DW-1:0] csr_wdata,
    output logic [DW-1:0] csr_rdata,
    output logic          illegal_csr_o,
    input  logic          trap_taken,
    input  logic [DW-1:0] trap_cause,
    input  logic [DW-1:0] trap_pc,
    input  logic          mret_i,
    input  logic          timer_irq_i,
    input  logic          ext_irq_i,
    output logic [DW-1:0] mstatus_o,
    output logic [DW-1:0] mie_o,
    output logic [DW-1:0] mip_o,
    output logic [DW-1:0] mtvec_o,
    output logic [DW-1:0] mcause_o,
    output logic [DW-1:0] mepc_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
    localparam logic [31:0] EPC_MASK   = 32'hFFFF_FFFC;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic        r_mip_mtip;
    logic        r_mip_meip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mscratch;
    logic [63:0] r_mcycle;

    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_mapped;
    logic        w_wr;

    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
    assign w_mie     = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
    assign w_mip     = {20'b0, r_mip_meip, 3'b0, r_mip_mtip, 7'b0};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_mapped = 1'b1;
        w_old    = '0;
        case (csr_addr)
            ADDR_MSTATUS:  w_old = w_mstatus;
            ADDR_MIE:      w_old = w_mie;
            ADDR_MTVEC:    w_old = r_mtvec;
            ADDR_MSCRATCH: w_old = r_mscratch;
            ADDR_MEPC:     w_old = r_mepc;
            ADDR_MCAUSE:   w_old = r_mcause;
            ADDR_MIP:      w_old = w_mip;
            ADDR_MCYCLE:   w_old = r_mcycle[31:0];
            ADDR_MCYCLEH:  w_old = r_mcycle[63:32];
            default:       w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (csr_op)
            OP_RW:   w_new = csr_wdata;
            OP_RS:   w_new = w_old | csr_wdata;
            OP_RC:   w_new = w_old & ~csr_wdata;
            default: w_new = w_old;
        endcase
    end

    assign w_wr          = (csr_op != OP_NONE) && w_mapped;
    assign illegal_csr_o = (csr_op != OP_NONE) && !w_mapped;
    assign csr_rdata     = w_old;

    // Priority: trap entry, then mret, then the CSR instruction's own write.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mip_mtip     <= 1'b0;
            r_mip_meip     <= 1'b0;
            r_mtvec        <= RESET_MTVEC & MTVEC_MASK;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mscratch     <= '0;
            r_mcycle       <= '0;
        end else begin
            r_mip_mtip <= timer_irq_i;
            r_mip_meip <= ext_irq_i;

            if (trap_taken) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= trap_pc & EPC_MASK;
                r_mcause       <= trap_cause;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr && csr_addr == ADDR_MSTATUS) begin
                r_mstatus_mie  <= w_new[3];
                r_mstatus_mpie <= w_new[7];
            end

            if (!trap_taken && w_wr && csr_addr == ADDR_MEPC)
                r_mepc <= w_new & EPC_MASK;
            if (!trap_taken && w_wr && csr_addr == ADDR_MCAUSE)
                r_mcause <= w_new;

            if (w_wr && csr_addr == ADDR_MIE) begin
                r_mie_mtie <= w_new[7];
                r_mie_meie <= w_new[11];
            end
            if (w_wr && csr_addr == ADDR_MTVEC)
                r_mtvec <= w_new & MTVEC_MASK;
            if (w_wr && csr_addr == ADDR_MSCRATCH)
                r_mscratch <= w_new;

            if (w_wr && csr_addr == ADDR_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], w_new};
            else if (w_wr && csr_addr == ADDR_MCYCLEH)
                r_mcycle <= {w_new, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;
        end
    end

    assign mstatus_o = w_mstatus;
    assign mie_o     = w_mie;
    assign mip_o     = w_mip;
    assign mtvec_o   = r_mtvec;
    assign mcause_o  = r_mcause;
    assign mepc_o    = r_mepc;

endmodule
